// File: rtl/piso_unloader_n_pkg.sv
// Shared definitions for the parallel-in/serial-out unloader: FSM state
// encodings and the bit-counter width helper.
package piso_unloader_n_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Counter width for an n-bit word; it holds at most n-1.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/piso_unloader_n_if.sv
// Handshake/data bundle between a word source, the unloader and the
// serial sink.
interface piso_unloader_n_if #(
  parameter int unsigned n = 4
);
  logic [n-1:0] D;
  logic         load;
  logic         en;
  logic         ready;
  logic         sout;
  logic         sout_valid;
  logic         busy;
  logic         done;

  modport master (
    output D, load, en,
    input  ready, sout, sout_valid, busy, done
  );

  modport slave (
    input  D, load, en,
    output ready, sout, sout_valid, busy, done
  );
endinterface

// File: rtl/piso_unloader_n_bit_counter_n.sv
// Loadable down-counter with enable and zero flag; saturates at zero
// rather than wrapping.
module bit_counter_n #(
  parameter int unsigned W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ld,
  input  logic [W-1:0] ld_val,
  input  logic         dec,
  output logic [W-1:0] cnt,
  output logic         zero
);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (ld) begin
      cnt <= ld_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/piso_unloader_n.sv
// Parallel-in/serial-out unloader: captures an n-bit word on load and
// emits it one bit per en tick, then pulses done for one cycle.
module piso_unloader_n
  import piso_unloader_n_pkg::*;
#(
  parameter int unsigned n         = 4,
  parameter bit          MSB_FIRST = 1'b1
) (
  input logic              clk,
  input logic              rst,
  piso_unloader_n_if.slave bus
);

  localparam int unsigned CNT_W = cnt_w(n);

  state_t           state;
  state_t           nstate;
  logic [n-1:0]     sr;
  logic [CNT_W-1:0] cnt;
  logic             cnt_zero;
  logic             sr_ld;
  logic             sr_sh;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= nstate;
    end
  end

  always_comb begin
    nstate = state;
    sr_ld  = 1'b0;
    sr_sh  = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.load) begin
          sr_ld  = 1'b1;
          nstate = SHIFT;
        end
      end
      SHIFT: begin
        if (bus.en) begin
          if (cnt_zero) begin
            nstate = DONE;
          end else begin
            sr_sh = 1'b1;
          end
        end
      end
      DONE: begin
        // back-to-back: a load here skips IDLE entirely
        if (bus.load) begin
          sr_ld  = 1'b1;
          nstate = SHIFT;
        end else begin
          nstate = IDLE;
        end
      end
      default: nstate = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sr <= '0;
    end else if (sr_ld) begin
      sr <= bus.D;
    end else if (sr_sh) begin
      if (MSB_FIRST) begin
        sr <= {sr[n-2:0], 1'b0};
      end else begin
        sr <= {1'b0, sr[n-1:1]};
      end
    end
  end

  bit_counter_n #(
    .W (CNT_W)
  ) u_cnt (
    .clk    (clk),
    .rst    (rst),
    .ld     (sr_ld),
    .ld_val (CNT_W'(n - 1)),
    .dec    (sr_sh),
    .cnt    (cnt),
    .zero   (cnt_zero)
  );

  // Outputs decode only registered state, so load/D never reach them combinationally.
  always_comb begin
    bus.busy       = (state == SHIFT);
    bus.sout_valid = (state == SHIFT);
    bus.done       = (state == DONE);
    bus.ready      = (state == IDLE) || (state == DONE);
    bus.sout       = 1'b0;
    if (state == SHIFT) begin
      bus.sout = MSB_FIRST ? sr[n-1] : sr[0];
    end
  end

endmodule

// File: tb/tb_piso_unloader_n.sv
// Bench for piso_unloader_n: a 4-bit MSB-first and an 8-bit LSB-first
// instance checked against a bit-queue reference model.
module tb_piso_unloader_n;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  piso_unloader_n_if #(.n(4)) a ();
  piso_unloader_n_if #(.n(8)) b ();

  piso_unloader_n #(.n(4), .MSB_FIRST(1'b1)) dut_a (.clk(clk), .rst(rst), .bus(a));
  piso_unloader_n #(.n(8), .MSB_FIRST(1'b0)) dut_b (.clk(clk), .rst(rst), .bus(b));

  int unsigned checks = 0;
  int unsigned errors = 0;

  // Reference: pending bits in transmit order plus a done flag.
  bit qa[$];
  bit qb[$];
  bit dpa = 1'b0;
  bit dpb = 1'b0;

  task automatic model_step(ref bit q[$], ref bit dp, input bit r, input bit ld,
                            input bit e, input logic [7:0] d, input int unsigned w,
                            input bit msb);
    if (r) begin
      q.delete();
      dp = 1'b0;
    end else if (q.size() != 0) begin
      dp = 1'b0;
      if (e) begin
        void'(q.pop_front());
        if (q.size() == 0) dp = 1'b1;
      end
    end else begin
      dp = 1'b0;
      if (ld) begin
        for (int i = 0; i < int'(w); i++) q.push_back(msb ? d[w-1-i] : d[i]);
      end
    end
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %b expected %b at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    bit ba;
    bit bb;
    ba = (qa.size() != 0);
    bb = (qb.size() != 0);
    chk("a.busy",       a.busy,       ba);
    chk("a.sout_valid", a.sout_valid, ba);
    chk("a.sout",       a.sout,       ba ? qa[0] : 1'b0);
    chk("a.done",       a.done,       dpa);
    chk("a.ready",      a.ready,      !ba);
    chk("b.busy",       b.busy,       bb);
    chk("b.sout_valid", b.sout_valid, bb);
    chk("b.sout",       b.sout,       bb ? qb[0] : 1'b0);
    chk("b.done",       b.done,       dpb);
    chk("b.ready",      b.ready,      !bb);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step(qa, dpa, rst, a.load, a.en, 8'(a.D), 4, 1'b1);
    model_step(qb, dpb, rst, b.load, b.en, b.D, 8, 1'b0);
    @(negedge clk);
    check_all();
  endtask

  logic [3:0] got4;
  logic [7:0] got8;

  initial begin
    rst = 1'b1;
    a.load = 1'b1; a.D = 4'hF; a.en = 1'b1;
    b.load = 1'b1; b.D = 8'hFF; b.en = 1'b1;
    cycle();
    cycle();

    // Basic MSB-first
    rst = 1'b0;
    b.load = 1'b0;
    a.D = 4'b1011;
    cycle();
    a.load = 1'b0;
    got4 = '0;
    for (int i = 0; i < 4; i++) begin
      got4 = {got4[2:0], a.sout};
      cycle();
    end
    chk("basic.seq0", got4[3], 1'b1);
    chk("basic.seq1", got4[2], 1'b0);
    chk("basic.seq2", got4[1], 1'b1);
    chk("basic.seq3", got4[0], 1'b1);
    chk("basic.done", a.done, 1'b1);
    cycle();
    chk("basic.idle", a.ready & ~a.done, 1'b1);

    // Tick gating with D change mid-transfer
    a.D = 4'b1001; a.load = 1'b1; a.en = 1'b0;
    cycle();
    a.load = 1'b0;
    for (int c = 0; c < 15; c++) begin
      a.en = ((c % 3) == 2);
      if (c == 4) a.D = 4'h6;
      cycle();
    end
    a.en = 1'b1;
    for (int c = 0; c < 3; c++) cycle();

    // Back-to-back with load held high
    a.D = 4'hA; a.load = 1'b1;
    cycle();
    a.D = 4'h5;
    for (int c = 0; c < 12; c++) begin
      if (c == 6) a.load = 1'b0;
      cycle();
    end

    // Abort after two bits
    a.D = 4'hC; a.load = 1'b1;
    cycle();
    a.load = 1'b0;
    cycle();
    cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    chk("abort.valid", a.sout_valid, 1'b0);
    for (int c = 0; c < 3; c++) cycle();

    // LSB-first, n=8
    b.D = 8'h81; b.load = 1'b1;
    cycle();
    b.load = 1'b0;
    got8 = '0;
    for (int i = 0; i < 8; i++) begin
      got8 = {got8[6:0], b.sout};
      cycle();
    end
    chk("lsb81.first", got8[7], 1'b1);
    chk("lsb81.mid",   |got8[6:1], 1'b0);
    chk("lsb81.last",  got8[0], 1'b1);
    b.D = 8'h02; b.load = 1'b1;
    cycle();
    b.load = 1'b0;
    got8 = '0;
    for (int i = 0; i < 8; i++) begin
      got8 = {got8[6:0], b.sout};
      cycle();
    end
    chk("lsb02.b0", got8[7], 1'b0);
    chk("lsb02.b1", got8[6], 1'b1);
    chk("lsb02.rest", |got8[5:0], 1'b0);
    cycle();

    // Randomized traffic on both instances
    for (int c = 0; c < 400; c++) begin
      rst    = ($urandom_range(0, 63) == 0);
      a.load = $urandom_range(0, 1);
      a.en   = ($urandom_range(0, 3) != 0);
      a.D    = 4'($urandom);
      b.load = $urandom_range(0, 1);
      b.en   = ($urandom_range(0, 2) != 0);
      b.D    = 8'($urandom);
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
